// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART transmitter and receiver:
//               frame data width, transmitter state encoding and the
//               clock-to-baud divider calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Data bits per frame (8N1 / 8N2 framing)
    localparam int unsigned UART_DATA_BITS = 8;

    // Transmitter state encoding
    localparam int unsigned c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_START = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA  = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_STOP  = 2'd3;

    // System clocks per line bit, truncated. A zero baud rate yields 0 so
    // that the divider range check in the users rejects it at elaboration
    // instead of dividing by zero.
    function automatic int unsigned uart_baud_div(
        input int unsigned clk_freq,
        input int unsigned baud
    );
        if (baud == 0) begin
            return 0;
        end
        return clk_freq / baud;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period timer. Counts 0..BAUD_DIV-1 while enabled and
//               flags the terminal count; held at zero while disabled so
//               every enabled run begins with a full bit period.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               en   - count enable (low clears the counter)
//               tick - high on the terminal count while enabled
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned c_CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(BAUD_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_baud_tick: BAUD_DIV must be at least 2");
    end

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_TERM) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // Gated by en so a stale count can never advance an idle FSM
    assign tick = en && (r_cnt == c_TERM);

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmitter, 8 data bits LSB first, 1 or 2 stop bits.
//               Accepts one byte per frame through a valid/ready handshake
//               and derives its own bit timing from the system clock.
// Ports       : clk      - system clock, all logic on rising edge
//               rst      - synchronous active-high reset
//               tx_data  - byte to send, captured on the acceptance cycle
//               tx_valid - producer offers tx_data
//               tx_ready - block accepts a byte this cycle (state is idle)
//               rs232_tx - registered serial line, idles high
//               tx_busy  - registered, high from start bit to last stop bit
//               tx_done  - one-cycle pulse after the last stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rs232_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned c_BAUD_DIV  = uart_baud_div(CLK_FREQ, BAUD);
    localparam int unsigned c_BIT_IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [c_BIT_IDX_W-1:0] c_LAST_BIT = c_BIT_IDX_W'(UART_DATA_BITS - 1);
    // Index of the final stop bit: 0 for one stop bit, 1 for two
    localparam logic c_LAST_STOP = 1'(STOP_BITS - 1);

    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    if (c_BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_frame: CLK_FREQ/BAUD must be at least 2");
    end

    logic [c_STATE_W-1:0]      r_state;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [c_BIT_IDX_W-1:0]    r_bit_idx;
    logic                      r_stop_idx;
    logic                      r_tx;
    logic                      r_busy;
    logic                      r_done;
    logic                      w_tick;
    logic                      w_timer_en;

    // The bit timer runs only while a frame is on the line, so the first
    // tick of a frame lands exactly one bit period after acceptance.
    assign w_timer_en = (r_state != c_ST_IDLE);

    uart_baud_tick #(
        .BAUD_DIV (c_BAUD_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (w_timer_en),
        .tick (w_tick)
    );

    // rs232_tx always carries the level of the state being entered, so the
    // line changes on the same edge as the state and never passes through
    // combinational logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (tx_valid) begin
                        r_shift   <= tx_data;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_ST_START;
                    end
                end

                c_ST_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                        r_bit_idx <= '0;
                        r_state   <= c_ST_DATA;
                    end
                end

                c_ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= c_ST_STOP;
                        end else begin
                            // r_shift[0] already holds the next bit to send
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end

                c_ST_STOP: begin
                    if (w_tick) begin
                        if (r_stop_idx == c_LAST_STOP) begin
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_bit_idx <= '0;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Ready depends only on state, so a byte can be accepted on the same
    // cycle that tx_done pulses.
    assign tx_ready = (r_state == c_ST_IDLE);
    assign rs232_tx = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule : uart_tx_frame
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame. One instance with one
//               stop bit and one with two share the stimulus; the checks
//               look at the instance selected by sel. Expected line levels
//               come from a frame bit list built from the byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    localparam int unsigned TB_CLK  = 1000;
    localparam int unsigned TB_BAUD = 100;
    localparam int unsigned TB_DIV  = TB_CLK / TB_BAUD;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       sel      = 1'b0;

    logic ready1, line1, busy1, done1;
    logic ready2, line2, busy2, done2;

    wire obs_ready = sel ? ready2 : ready1;
    wire obs_line  = sel ? line2  : line1;
    wire obs_busy  = sel ? busy2  : busy1;
    wire obs_done  = sel ? done2  : done1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.CLK_FREQ(TB_CLK), .BAUD(TB_BAUD), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready1), .rs232_tx(line1), .tx_busy(busy1), .tx_done(done1)
    );

    uart_tx_frame #(.CLK_FREQ(TB_CLK), .BAUD(TB_BAUD), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready2), .rs232_tx(line2), .tx_busy(busy2), .tx_done(done2)
    );

    // Line level n cycles after acceptance (n starting at 1): the frame is a
    // list of bits (start, data LSB first, stops), each lasting TB_DIV cycles.
    function automatic logic model_line(input logic [7:0] d, input int stop_bits, input int n);
        logic frame[$];
        frame.push_back(1'b0);
        for (int i = 0; i < 8; i++) frame.push_back(d[i]);
        for (int i = 0; i < stop_bits; i++) frame.push_back(1'b1);
        return frame[(n - 1) / TB_DIV];
    endfunction

    task automatic check_idle(input string tag);
        n_cmp++;
        if (obs_line !== 1'b1) begin n_err++; $display("FAIL %s line got=%b exp=1", tag, obs_line); end
        n_cmp++;
        if (obs_busy !== 1'b0) begin n_err++; $display("FAIL %s busy got=%b exp=0", tag, obs_busy); end
        n_cmp++;
        if (obs_ready !== 1'b1) begin n_err++; $display("FAIL %s ready got=%b exp=1", tag, obs_ready); end
    endtask

    // Presents a byte and returns at a falling edge where ready is high, so
    // the next rising edge is the acceptance edge.
    task automatic start_frame(input logic [7:0] d);
        int waited = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (obs_ready !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (obs_ready !== 1'b1) begin n_err++; $display("FAIL accept_wait ready got=%b exp=1", obs_ready); end
    endtask

    // Checks a whole frame cycle by cycle, starting right after acceptance,
    // plus the idle cycle carrying tx_done. keep_valid leaves tx_valid high
    // with next_d so the next frame is accepted on the done cycle. A nonzero
    // glitch_n offers 0xFF for one cycle mid-frame.
    task automatic check_frame(input logic [7:0] d, input int stop_bits, input bit keep_valid,
                               input logic [7:0] next_d, input int glitch_n, output int start_cyc);
        int   len = (9 + stop_bits) * TB_DIV;
        logic exp_line;
        start_cyc = 0;
        for (int n = 1; n <= len + 1; n++) begin
            @(negedge clk);
            if (n == 1) start_cyc = cyc;
            if (n <= len) begin
                exp_line = model_line(d, stop_bits, n);
                n_cmp++;
                if (obs_line !== exp_line) begin
                    n_err++;
                    $display("FAIL frame_line byte=%h n=%0d got=%b exp=%b", d, n, obs_line, exp_line);
                end
                n_cmp++;
                if (obs_busy !== 1'b1) begin n_err++; $display("FAIL frame_busy byte=%h n=%0d got=%b exp=1", d, n, obs_busy); end
                n_cmp++;
                if (obs_done !== 1'b0) begin n_err++; $display("FAIL frame_done byte=%h n=%0d got=%b exp=0", d, n, obs_done); end
                n_cmp++;
                if (obs_ready !== 1'b0) begin n_err++; $display("FAIL frame_ready byte=%h n=%0d got=%b exp=0", d, n, obs_ready); end
            end else begin
                n_cmp++;
                if (obs_done !== 1'b1) begin n_err++; $display("FAIL done_pulse byte=%h got=%b exp=1", d, obs_done); end
                check_idle("frame_end");
            end
            if (n == 1) begin
                if (keep_valid) tx_data = next_d;
                else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                end
            end
            if (glitch_n != 0 && n == glitch_n) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (glitch_n != 0 && n == glitch_n + 1) tx_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        int s;
        sel = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check_idle("reset");
            n_cmp++;
            if (obs_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", obs_done); end
        end
        rst = 1'b0;   // valid still high: accepted on the next edge
        check_frame(8'h5A, 1, 1'b0, 8'h00, 0, s);
    endtask

    task automatic test_single();
        int s;
        sel = 1'b0;
        start_frame(8'h55);
        check_frame(8'h55, 1, 1'b0, 8'h00, 0, s);
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        sel = 1'b0;
        start_frame(8'hA3);
        check_frame(8'hA3, 1, 1'b1, 8'h0F, 0, s1);
        check_frame(8'h0F, 1, 1'b0, 8'h00, 0, s2);
        n_cmp++;
        if (s2 - s1 != 101) begin n_err++; $display("FAIL b2b_spacing got=%0d exp=101", s2 - s1); end
    endtask

    task automatic test_ignored_input();
        logic [7:0] d;
        int s;
        sel = 1'b0;
        d = 8'($urandom);
        start_frame(d);
        check_frame(d, 1, 1'b0, 8'h00, 30, s);
        repeat (30) begin
            @(negedge clk);
            check_idle("no_second_frame");
        end
    endtask

    task automatic test_midframe_reset();
        int   s;
        logic exp_line;
        sel = 1'b0;
        start_frame(8'h00);
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 1) tx_valid = 1'b0;
            exp_line = model_line(8'h00, 1, n);
            n_cmp++;
            if (obs_line !== exp_line) begin n_err++; $display("FAIL abort_line n=%0d got=%b exp=%b", n, obs_line, exp_line); end
        end
        rst = 1'b1;   // lands during data bit 3
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort");
        n_cmp++;
        if (obs_done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b exp=0", obs_done); end
        repeat (20) begin
            @(negedge clk);
            n_cmp++;
            if (obs_done !== 1'b0 || obs_line !== 1'b1) begin
                n_err++;
                $display("FAIL post_abort done=%b line=%b exp done=0 line=1", obs_done, obs_line);
            end
        end
        start_frame(8'h81);
        check_frame(8'h81, 1, 1'b0, 8'h00, 0, s);
    endtask

    task automatic test_random();
        logic [7:0] d, nd;
        int s;
        sel = 1'b0;
        d = 8'($urandom);
        start_frame(d);
        for (int i = 0; i < 4; i++) begin
            nd = 8'($urandom);
            check_frame(d, 1, (i < 3), nd, 0, s);
            d = nd;
        end
    endtask

    task automatic test_two_stop();
        int s1, s2;
        logic [7:0] nd;
        // clear the two-stop instance, which has been following the stimulus
        @(negedge clk);
        rst      = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        check_idle("two_stop_reset");
        nd = 8'($urandom);
        start_frame(8'h3C);
        check_frame(8'h3C, 2, 1'b1, nd, 0, s1);
        check_frame(nd, 2, 1'b0, 8'h00, 0, s2);
        n_cmp++;
        if (s2 - s1 != 111) begin n_err++; $display("FAIL two_stop_spacing got=%0d exp=111", s2 - s1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_input();
        test_midframe_reset();
        test_random();
        test_two_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx_frame
`default_nettype wire
